snake_move_scheduler: RTL
=========================

# snake_move_scheduler

Sequencing controller for the snake position datapath. Turns raw direction and pause buttons into a clean stream of move commands: one-cycle `mover` strobes at a programmable rate, each with a stable `accion` direction code. Turns go through a 2-deep queue with reversal rejection. Sits between the board buttons and the position/graphics logic; all logic runs on `uclk`.

## Interface
Parameters:
- `TICK_DIV`, 4_000_000: initial `uclk` cycles between moves (10 Hz at 40 MHz).
- `MIN_TICK_DIV`, 1_000_000: floor for the move period.
- `SPEED_STEP`, 250_000: period decrement per `speed_up` strobe.
- `CNT_W`, 23: width of the period and tick counters. Must satisfy 2^CNT_W > TICK_DIV.

Ports:
- `uclk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `btn_top`, `btn_bottom`, `btn_left`, `btn_right`, in, 1 each: raw asynchronous buttons, active-high.
- `btn_pause`, in, 1: raw asynchronous pause/resume toggle.
- `speed_up`, in, 1: one-cycle strobe, synchronous to `uclk`; shortens the move period.
- `mover`, out, 1: one-cycle move strobe.
- `accion`, out, 3: direction code. 0 none, 1 up, 2 down, 3 left, 4 right.
- `state`, out, 2: 0 IDLE, 1 RUN, 2 PAUSED.
- `queue_count`, out, 2: pending turns, 0..2.

## Operation
- **Button conditioning:** each button passes a 2-flop synchronizer, then a rising-edge detector. Only edges act. Held buttons never repeat.
- **Simultaneous edges:** if several direction edges occur in one cycle, only one is considered, by priority top > bottom > left > right.
- **Reference for rejection ("tail"):** the last queue entry if the queue is non-empty, otherwise `accion`.
- **Rejection:** a candidate equal to the tail or opposite to it (1↔2, 3↔4) is dropped. A candidate arriving while the queue is full (2) is dropped.
- **IDLE:**
  - Any direction edge loads `accion` directly (bypassing the queue), clears the tick counter and enters RUN.
  - The reversal rule is not applied here, because `accion` = 0.
  - Pause edges are ignored.
- **RUN:**
  - The tick counter increments each cycle.
  - When the counter reaches `period`−1: it clears, the queue head (if any) pops into `accion`, and `mover` pulses in that same cycle with the updated `accion`.
  - Accepted direction edges are pushed to the queue.
- **Push and pop in the same cycle:** the push is evaluated against the tail computed before the pop. The count is then updated as count − 1 + 1.
- **PAUSED:** entered by a pause edge from RUN. The counter is frozen, there are no strobes, and direction edges are ignored. The queue is preserved. A pause edge returns to RUN, and counting resumes from the frozen value.
- **`speed_up`:** the period becomes max(period − `SPEED_STEP`, `MIN_TICK_DIV`), saturating. It is accepted in any state and takes effect at the next terminal-count compare.
- **Reset mid-operation:** overrides everything in the same edge. It drops any in-flight `mover`.

## Timing
- **Reset values:** `mover`=0, `accion`=0, `state`=IDLE, `queue_count`=0, period=`TICK_DIV`, counter=0. Synchronizer flops = 0, so a button held through reset produces an edge 3 cycles after reset deasserts.
- **Button latency:** 3 `uclk` cycles from a raw rising edge to the queue/`accion` update (2 sync flops + edge register).
- **First move:** the first `mover` comes exactly `period` cycles after the IDLE→RUN transition cycle.
- **Move spacing:** in RUN, `mover` is high for exactly 1 cycle every `period` cycles.
- **`accion` stability:** `accion` changes only on a `mover` cycle, or on the IDLE→RUN load. It is registered and stable between strobes.
- **Counter widths:** counter and period are `CNT_W` bits unsigned. The decrement is saturating, with no wrap-around.

## Structure
- **Package `snake_pkg`:**
  - Direction codes `DIR_NONE`/`DIR_UP`/`DIR_DOWN`/`DIR_LEFT`/`DIR_RIGHT` (3 bits), shared with the position datapath.
  - State encoding.
  - An `opposite()` function.
- **Sub-module `btn_edge_sync`:** 2-flop synchronizer plus rising-edge pulse, instantiated 5 times.
- **Queue:** implemented inline as two 3-bit registers plus a count. No generic FIFO.

## Test plan
All scenarios use `TICK_DIV`=8, `MIN_TICK_DIV`=4, `SPEED_STEP`=2.
1. **Start and steady rate:** reset, then pulse `btn_right`. `state`=RUN and `accion`=4 three cycles after the press. `mover` pulses 8 cycles later and every 8 cycles after that, with `accion`=4 each time.
2. **Reversal rejection and queueing:** in RUN with right, press left → `queue_count` stays 0. Press top, then left → `queue_count`=2. The next two strobes carry `accion`=1, then 3.
3. **Queue full and simultaneous edges:** with the queue holding [1,3], press bottom → dropped, `queue_count`=2. From an empty queue with `accion`=4, press top and left in the same cycle → only 1 is queued.
4. **Pause:** pause at counter=5 → no `mover` for 50 cycles, and presses are ignored. Resume → `mover` 3 cycles after the resume edge registers.
5. **Speed-up saturation:** three `speed_up` strobes → strobe spacing goes 8, 6, 4, 4.
6. **Reset mid-run:** assert `reset` on a `mover` cycle with `queue_count`=2 → on the next cycle all outputs take their reset values and `state`=IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction codes, scheduler states and direction helpers shared with the position datapath
package snake_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    function automatic logic [2:0] opposite(input logic [2:0] dir);
        case (dir)
            DIR_UP:    opposite = DIR_DOWN;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_RIGHT: opposite = DIR_LEFT;
            default:   opposite = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snake_move_scheduler_btn_edge_sync.sv
// rtl/snake_move_scheduler_btn_edge_sync.sv - two-flop button synchronizer with rising-edge pulse
module btn_edge_sync (
    input  logic uclk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1, sync2, sync2_q;

    always_ff @(posedge uclk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    assign pulse = sync2 & ~sync2_q;

endmodule

// File: rtl/snake_move_scheduler.sv
// rtl/snake_move_scheduler.sv - turns button edges into rate-limited move strobes with a 2-deep turn queue
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int TICK_DIV     = 4_000_000,
    parameter int MIN_TICK_DIV = 1_000_000,
    parameter int SPEED_STEP   = 250_000,
    parameter int CNT_W        = 23
) (
    input  logic       uclk,
    input  logic       reset,
    input  logic       btn_top,
    input  logic       btn_bottom,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    input  logic       speed_up,
    output logic       mover,
    output logic [2:0] accion,
    output logic [1:0] state,
    output logic [1:0] queue_count
);

    localparam logic [CNT_W-1:0] INIT_W  = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_TICK_DIV);
    localparam logic [CNT_W-1:0] STEP_W  = CNT_W'(SPEED_STEP);
    localparam logic [CNT_W:0]   SAT_LIM = (CNT_W+1)'(MIN_TICK_DIV + SPEED_STEP);

    logic p_top, p_bottom, p_left, p_right, p_pause;

    btn_edge_sync u_sync_top    (.uclk(uclk), .reset(reset), .btn(btn_top),    .pulse(p_top));
    btn_edge_sync u_sync_bottom (.uclk(uclk), .reset(reset), .btn(btn_bottom), .pulse(p_bottom));
    btn_edge_sync u_sync_left   (.uclk(uclk), .reset(reset), .btn(btn_left),   .pulse(p_left));
    btn_edge_sync u_sync_right  (.uclk(uclk), .reset(reset), .btn(btn_right),  .pulse(p_right));
    btn_edge_sync u_sync_pause  (.uclk(uclk), .reset(reset), .btn(btn_pause),  .pulse(p_pause));

    state_t           st, st_nxt;
    logic [2:0]       accion_nxt, q0, q1, q0_nxt, q1_nxt, cand, tail;
    logic [1:0]       count, count_nxt, count_pop;
    logic [CNT_W-1:0] cnt, cnt_nxt, period, period_nxt;
    logic             mover_nxt, tc, accept;

    assign state       = st;
    assign queue_count = count;

    always_comb begin
        if (p_top)         cand = DIR_UP;
        else if (p_bottom) cand = DIR_DOWN;
        else if (p_left)   cand = DIR_LEFT;
        else if (p_right)  cand = DIR_RIGHT;
        else               cand = DIR_NONE;
    end

    // Rejection is judged against the newest pending turn, not the current heading
    assign tail   = (count == 2'd0) ? accion : (count == 2'd1) ? q0 : q1;
    assign accept = (cand != DIR_NONE) && (cand != tail) && (cand != opposite(tail)) && (count != 2'd2);
    // >= keeps the counter from running away when the period shrinks below it
    assign tc     = (cnt >= period - CNT_W'(1));

    always_comb begin
        st_nxt     = st;
        accion_nxt = accion;
        q0_nxt     = q0;
        q1_nxt     = q1;
        count_nxt  = count;
        count_pop  = count;
        cnt_nxt    = cnt;
        mover_nxt  = 1'b0;
        period_nxt = period;

        if (speed_up)
            period_nxt = ({1'b0, period} >= SAT_LIM) ? period - STEP_W : MIN_W;

        case (st)
            ST_IDLE: begin
                if (cand != DIR_NONE) begin
                    accion_nxt = cand;
                    cnt_nxt    = '0;
                    st_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (p_pause) begin
                    st_nxt = ST_PAUSED;
                end else begin
                    if (tc) begin
                        cnt_nxt   = '0;
                        mover_nxt = 1'b1;
                        if (count != 2'd0) begin
                            accion_nxt = q0;
                            q0_nxt     = q1;
                            count_pop  = count - 2'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    if (accept) begin
                        if (count_pop == 2'd0) q0_nxt = cand;
                        else                   q1_nxt = cand;
                    end
                    count_nxt = count_pop + {1'b0, accept};
                end
            end
            ST_PAUSED: begin
                if (p_pause) st_nxt = ST_RUN;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge uclk) begin
        if (reset) begin
            st     <= ST_IDLE;
            accion <= DIR_NONE;
            q0     <= DIR_NONE;
            q1     <= DIR_NONE;
            count  <= 2'd0;
            cnt    <= '0;
            period <= INIT_W;
            mover  <= 1'b0;
        end else begin
            st     <= st_nxt;
            accion <= accion_nxt;
            q0     <= q0_nxt;
            q1     <= q1_nxt;
            count  <= count_nxt;
            cnt    <= cnt_nxt;
            period <= period_nxt;
            mover  <= mover_nxt;
        end
    end

endmodule
